// File: rtl/exec_alu_if.sv
// exec_alu_if: operand, control, result and flag signals of the execute-stage ALU
interface exec_alu_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       aluop;
    logic [3:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flag_we;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] br_off;
    logic [3:0]       gout;
    logic [WIDTH-1:0] result;
    logic             zout;
    logic             vflag;
    logic             nflag;
    logic             zflag;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] br_target;

    modport master (
        output aluop, funct, a, b, flag_we, pc, br_off,
        input  gout, result, zout, vflag, nflag, zflag, pc_plus4, br_target
    );

    modport slave (
        input  aluop, funct, a, b, flag_we, pc, br_off,
        output gout, result, zout, vflag, nflag, zflag, pc_plus4, br_target
    );
endinterface

// File: rtl/exec_alu_unit.sv
// exec_alu_unit: ALU control decode, ALU with zero output, N/Z/V status register and PC adders
module exec_alu_unit #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    exec_alu_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    logic [3:0]       r_op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_v;
    logic             sub_v;
    logic             next_v;

    // R-type funct to operation code; unknown functs fall back to add
    always_comb begin
        r_op = bus.funct == 4'b0010 ? 4'b0110 :
               bus.funct == 4'b0100 ? 4'b0000 :
               bus.funct == 4'b0101 ? 4'b0001 :
               bus.funct == 4'b0110 ? 4'b0011 :
               bus.funct == 4'b0111 ? 4'b1100 :
               bus.funct == 4'b1010 ? 4'b0111 : 4'b0010;
    end

    // ALUOp selects a fixed operation or defers to the funct decode
    always_comb begin
        bus.gout = bus.aluop == 3'b001 ? 4'b0110 :
                   bus.aluop == 3'b010 ? r_op    :
                   bus.aluop == 3'b011 ? 4'b1101 :
                   bus.aluop == 3'b100 ? 4'b0001 :
                   bus.aluop == 3'b101 ? 4'b0000 :
                   bus.aluop == 3'b110 ? 4'b0111 : 4'b0010;
    end

    // shared adder/subtractor and their signed-overflow conditions; slt reuses the subtract
    always_comb begin
        sum   = bus.a + bus.b;
        diff  = bus.a - bus.b;
        add_v = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
        sub_v = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
    end

    // operation select, zero detect and next overflow flag
    always_comb begin
        bus.result = bus.gout == 4'b0000 ? bus.a & bus.b    :
                     bus.gout == 4'b0001 ? bus.a | bus.b    :
                     bus.gout == 4'b0011 ? bus.a ^ bus.b    :
                     bus.gout == 4'b1100 ? ~(bus.a | bus.b) :
                     bus.gout == 4'b1101 ? ~(bus.a & bus.b) :
                     bus.gout == 4'b0010 ? sum              :
                     bus.gout == 4'b0110 ? diff             :
                     bus.gout == 4'b0111 ? {{MSB{1'b0}}, diff[MSB] ^ sub_v} : '0;
        bus.zout   = bus.result == '0;
        next_v     = bus.gout == 4'b0010 ? add_v :
                     bus.gout == 4'b0110 ? sub_v : 1'b0;
    end

    // status register: captures the flags of flag-writing instructions, cleared at once by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.vflag <= 1'b0;
            bus.nflag <= 1'b0;
            bus.zflag <= 1'b0;
        end else if (bus.flag_we) begin
            bus.vflag <= next_v;
            bus.nflag <= bus.result[MSB];
            bus.zflag <= bus.zout;
        end
    end

    // sequential and branch-target PC adders, both wrapping
    always_comb begin
        bus.pc_plus4  = bus.pc + WIDTH'(4);
        bus.br_target = bus.pc_plus4 + bus.br_off;
    end
endmodule

// File: tb/tb_exec_alu_unit.sv
// tb_exec_alu_unit: vector table, flag/reset sequences and randomized model check of exec_alu_unit
module tb_exec_alu_unit;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    exec_alu_if #(.WIDTH(32)) bus();

    exec_alu_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  aluop;
        logic [3:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  g;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [2:0] op, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b, input logic we);
        bus.aluop   = op;
        bus.funct   = fn;
        bus.a       = a;
        bus.b       = b;
        bus.flag_we = we;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string name, input logic v, input logic n, input logic z);
        check({name, ".v"}, {31'b0, bus.vflag}, {31'b0, v});
        check({name, ".n"}, {31'b0, bus.nflag}, {31'b0, n});
        check({name, ".z"}, {31'b0, bus.zflag}, {31'b0, z});
    endtask

    // reference model: operation named from aluop/funct, evaluated with plain integer arithmetic
    function automatic logic [3:0] m_gout(input logic [2:0] op, input logic [3:0] fn);
        case (op)
            3'b001: return 4'b0110;
            3'b011: return 4'b1101;
            3'b100: return 4'b0001;
            3'b101: return 4'b0000;
            3'b110: return 4'b0111;
            3'b010:
                case (fn)
                    4'b0010: return 4'b0110;
                    4'b0100: return 4'b0000;
                    4'b0101: return 4'b0001;
                    4'b0110: return 4'b0011;
                    4'b0111: return 4'b1100;
                    4'b1010: return 4'b0111;
                    default: return 4'b0010;
                endcase
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic [31:0] m_res(input logic [3:0] g, input logic [31:0] a, input logic [31:0] b);
        case (g)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0011: return a ^ b;
            4'b1100: return ~(a | b);
            4'b1101: return ~(a & b);
            4'b0010: return 32'(longint'(a) + longint'(b));
            4'b0110: return 32'(longint'(a) - longint'(b));
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_v(input logic [3:0] g, input logic [31:0] a, input logic [31:0] b);
        longint r;
        if (g == 4'b0010) r = longint'($signed(a)) + longint'($signed(b));
        else if (g == 4'b0110) r = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    initial begin
        logic        ev, en, ez;
        logic [3:0]  g;
        logic [31:0] r, pc, off;
        vecs[0]  = '{3'b010, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b0};
        vecs[1]  = '{3'b001, 4'b0000, 32'h00000005, 32'h00000005, 4'b0110, 32'h00000000, 1'b1};
        vecs[2]  = '{3'b010, 4'b1010, 32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, 1'b0};
        vecs[3]  = '{3'b010, 4'b1010, 32'h80000000, 32'h7FFFFFFF, 4'b0111, 32'h00000001, 1'b0};
        vecs[4]  = '{3'b010, 4'b1010, 32'h00000005, 32'h00000003, 4'b0111, 32'h00000000, 1'b1};
        vecs[5]  = '{3'b011, 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b1101, 32'hFF0FFF0F, 1'b0};
        vecs[6]  = '{3'b010, 4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0011, 32'hFF00FF00, 1'b0};
        vecs[7]  = '{3'b010, 4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b1100, 32'h000F000F, 1'b0};
        vecs[8]  = '{3'b010, 4'b1111, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0010, 32'h00E100E0, 1'b0};
        vecs[9]  = '{3'b100, 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0001, 32'hFFF0FFF0, 1'b0};
        vecs[10] = '{3'b101, 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000, 32'h00F000F0, 1'b0};
        vecs[11] = '{3'b110, 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0111, 32'h00000001, 1'b0};
        vecs[12] = '{3'b111, 4'b0000, 32'h00000001, 32'h00000002, 4'b0010, 32'h00000003, 1'b0};
        vecs[13] = '{3'b000, 4'b0000, 32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 1'b1};
        vecs[14] = '{3'b010, 4'b0010, 32'h00000003, 32'h00000005, 4'b0110, 32'hFFFFFFFE, 1'b0};
        vecs[15] = '{3'b010, 4'b0100, 32'h0000FF00, 32'h00FFF000, 4'b0000, 32'h0000F000, 1'b0};
        vecs[16] = '{3'b010, 4'b0101, 32'h0000FF00, 32'h00FFF000, 4'b0001, 32'h00FFFF00, 1'b0};
        vecs[17] = '{3'b010, 4'b0001, 32'h00000000, 32'h00000000, 4'b0010, 32'h00000000, 1'b1};

        rst = 1'b1;
        apply(3'b000, 4'b0000, 32'h0, 32'h0, 1'b0);
        bus.pc = 32'h0;
        bus.br_off = 32'h0;
        #12;
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b, 1'b0);
            #1;
            check($sformatf("vec%0d.gout", i), {28'b0, bus.gout}, {28'b0, vecs[i].g});
            check($sformatf("vec%0d.result", i), bus.result, vecs[i].r);
            check($sformatf("vec%0d.zout", i), {31'b0, bus.zout}, {31'b0, vecs[i].z});
        end

        bus.pc = 32'h00000010;
        bus.br_off = 32'hFFFFFFF8;
        #1;
        check("pc_plus4", bus.pc_plus4, 32'h00000014);
        check("br_target", bus.br_target, 32'h0000000C);
        bus.pc = 32'hFFFFFFFC;
        bus.br_off = 32'h00000008;
        #1;
        check("pc_plus4_wrap", bus.pc_plus4, 32'h00000000);
        check("br_target_wrap", bus.br_target, 32'h00000008);

        tick;
        apply(3'b010, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        tick;
        check_flags("add_ovf", 1'b1, 1'b1, 1'b0);
        apply(3'b001, 4'b0000, 32'h00000005, 32'h00000005, 1'b1);
        tick;
        check_flags("sub_zero", 1'b0, 1'b0, 1'b1);
        apply(3'b010, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        tick;
        check_flags("hold", 1'b0, 1'b0, 1'b1);
        apply(3'b001, 4'b0000, 32'h80000000, 32'h00000001, 1'b1);
        tick;
        check_flags("sub_ovf", 1'b1, 1'b0, 1'b0);
        apply(3'b110, 4'b0000, 32'h80000000, 32'h7FFFFFFF, 1'b1);
        tick;
        check_flags("slt_nov", 1'b0, 1'b0, 1'b0);

        apply(3'b010, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        tick;
        check_flags("pre_rst", 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_flags("async_rst", 1'b0, 1'b0, 1'b0);
        tick;
        check_flags("rst_edge", 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        tick;
        check_flags("rst_release", 1'b1, 1'b1, 1'b0);

        #1 rst = 1'b1;
        #1 rst = 1'b0;
        ev = 1'b0;
        en = 1'b0;
        ez = 1'b0;
        for (int i = 0; i < 400; i++) begin
            apply(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 32'h80000000 - 32'($urandom_range(0, 2)) : $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom,
                  1'($urandom_range(0, 1)));
            pc = $urandom;
            off = $urandom;
            bus.pc = pc;
            bus.br_off = off;
            #1;
            g = m_gout(bus.aluop, bus.funct);
            r = m_res(g, bus.a, bus.b);
            check("rnd.gout", {28'b0, bus.gout}, {28'b0, g});
            check("rnd.result", bus.result, r);
            check("rnd.zout", {31'b0, bus.zout}, {31'b0, r == 32'h0});
            check("rnd.pc_plus4", bus.pc_plus4, 32'(longint'(pc) + 4));
            check("rnd.br_target", bus.br_target, 32'(longint'(pc) + 4 + longint'(off)));
            if (bus.flag_we) begin
                ev = m_v(g, bus.a, bus.b);
                en = r[31];
                ez = (r == 32'h0);
            end
            tick;
            check_flags("rnd", ev, en, ez);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exec_alu_unit.md
Name: exec_alu_unit

Overview:
- Execute-stage arithmetic block of the single-cycle 32-bit MIPS-style datapath.
- Contains an ALU-control decoder (ALUOp + funct to a 4-bit operation code) and a 32-bit ALU with a combinational zero output.
- Holds a clocked N/Z/V status register used by the flag-conditioned branches.
- Also contains the two PC adders: PC+4 and the branch target.

Parameters:
- WIDTH, 32, datapath width; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset of the status register.
- aluop  input  3  ALUOp{2,1,0} from the main control.
- funct  input  4  instruction bits [3:0].
- a  input  32  operand A (register read data 1).
- b  input  32  operand B (ALUSrc mux output).
- flag_we  input  1  status-register write enable.
- pc  input  32  current program counter.
- br_off  input  32  sign-extended offset, already shifted left by 2.
- gout  output  4  decoded ALU operation.
- result  output  32  ALU result.
- zout  output  1  combinational result==0.
- vflag  output  1  registered overflow flag.
- nflag  output  1  registered negative flag.
- zflag  output  1  registered zero flag.
- pc_plus4  output  32  pc + 4.
- br_target  output  32  pc_plus4 + br_off.

Behaviour:
- All outputs except vflag, nflag and zflag are purely combinational, with zero latency.

ALU control decode (gout):
- aluop 000: 0010 (add).
- aluop 001: 0110 (sub).
- aluop 011: 1101 (nand).
- aluop 100: 0001 (or).
- aluop 101: 0000 (and).
- aluop 110: 0111 (slt).
- aluop 111: 0010 (add).
- aluop 010 (R-type) decodes funct:
  - 0000 -> 0010 add
  - 0010 -> 0110 sub
  - 0100 -> 0000 and
  - 0101 -> 0001 or
  - 0110 -> 0011 xor
  - 0111 -> 1100 nor
  - 1010 -> 0111 slt
  - any other funct -> 0010 add

ALU operations by gout:
- 0000 a&b; 0001 a|b; 0011 a^b; 1100 ~(a|b); 1101 ~(a&b).
- 0010 a+b; 0110 a-b (two's complement, carry-out discarded).
- 0111 slt: result 32'd1 when a<b as signed, else 0. Compute from (sign of a-b) XOR (overflow of a-b) so that overflowing comparisons are correct.
- Any unlisted gout: result 0.

Combinational flags:
- zout = (result == 0).
- Next-N = result[31].
- Next-Z = zout.
- Next-V is the signed overflow of the operation:
  - add: a[31]==b[31] and result[31]!=a[31].
  - sub: a[31]!=b[31] and result[31]!=a[31].
  - all other operations, including slt: 0.

Status register:
- On posedge clk with flag_we=1: vflag/nflag/zflag <= next-V/N/Z.
- With flag_we=0: hold.
- rst=1 clears all three immediately, without waiting for clk, and overrides flag_we.
- Release of rst takes effect at the next enabled edge.
- Registered flags therefore reflect the last flag-writing instruction, not the current one.

Adders:
- pc_plus4 = pc + 32'h4, wrapping: 32'hFFFFFFFC gives 0.
- br_target = pc_plus4 + br_off, wrapping. A negative br_off branches backward.

Test Plan:
- aluop=010, funct=0000, a=32'h7FFFFFFF, b=1 -> gout=0010, result=32'h80000000, zout=0. After clk with flag_we=1: vflag=1, nflag=1, zflag=0.
- aluop=001, a=b=32'h00000005 -> gout=0110, result=0, zout=1. After clk with flag_we=1: zflag=1, vflag=0, nflag=0. With flag_we=0 and new operands, the flags hold.
- aluop=010, funct=1010: a=32'hFFFFFFFF, b=1 -> result=1. a=32'h80000000, b=32'h7FFFFFFF -> result=1 (overflowing subtract). a=5, b=3 -> result=0.
- Logic ops with a=32'hF0F0F0F0, b=32'h0FF00FF0:
  - aluop=011 -> result=32'hFF0FFF0F.
  - aluop=010, funct=0110 -> result=32'hFF00FF00.
  - funct=0111 -> 32'h000F000F.
  - aluop=010, funct=1111 -> gout=0010.
- pc=32'h00000010, br_off=32'hFFFFFFF8 -> pc_plus4=32'h14, br_target=32'h0C. pc=32'hFFFFFFFC -> pc_plus4=0.
- Set flags to N=1 and V=1, then assert rst between clock edges -> all flags read 0 before the next edge. A clk edge while rst is high keeps them 0.
